// File: rtl/car_pkg.sv
// ============================================================================
// car_pkg : shared codes for the maze-solving car (detect, motor, direction,
//           sequencer state encoding used by the LED display)
// Revision: 1.0
// ============================================================================
`default_nettype none

package car_pkg;

    localparam int CNT_W = 29;

    typedef enum logic [2:0] {
        DET_NONE = 3'b000,
        DET_R    = 3'b001,
        DET_M    = 3'b010,
        DET_MR   = 3'b011,
        DET_L    = 3'b100,
        DET_LR   = 3'b101,
        DET_LM   = 3'b110,
        DET_ALL  = 3'b111
    } det_t;

    typedef enum logic [2:0] {
        CMD_STOP  = 3'd0,
        CMD_FWD   = 3'd1,
        CMD_LEFT  = 3'd2,
        CMD_RIGHT = 3'd3,
        CMD_SPIN  = 3'd4
    } cmd_t;

    typedef enum logic [1:0] {
        DIR_LEFT     = 2'd0,
        DIR_STRAIGHT = 2'd1,
        DIR_RIGHT    = 2'd2
    } dir_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FOLLOW    = 4'd1,
        ST_SETTLE    = 4'd2,
        ST_TURN      = 4'd3,
        ST_UTURN     = 4'd4,
        ST_GOAL      = 4'd5,
        ST_EXHAUSTED = 4'd6,
        ST_FAULT     = 4'd7
    } state_t;

    // Every turn, including the one after a pop, is taken to the left.
    function automatic cmd_t state_cmd(input state_t s);
        cmd_t c;
        case (s)
            ST_FOLLOW, ST_SETTLE: c = CMD_FWD;
            ST_TURN:              c = CMD_LEFT;
            ST_UTURN:             c = CMD_SPIN;
            default:              c = CMD_STOP;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/turn_stack.sv
// ============================================================================
// turn_stack : LIFO of branch directions taken at junctions (2 bits/entry)
// Revision: 1.0
// ============================================================================
`default_nettype none

module turn_stack #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [1:0]               i_dir,
    output logic [1:0]               o_top,
    output logic [$clog2(DEPTH):0]   o_depth,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]    r_mem [DEPTH];
    logic [AW:0]   r_depth;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_depth == (AW+1)'(DEPTH));
    assign o_empty   = (r_depth == '0);
    assign w_do_push = i_push && !o_full && !i_clr;
    assign w_do_pop  = i_pop && !o_empty && !i_clr;
    assign w_wr_idx  = r_depth[AW-1:0];
    assign w_rd_idx  = w_wr_idx - AW'(1);
    assign o_top     = r_mem[w_rd_idx];
    assign o_depth   = r_depth;

    // Occupancy saturates at both ends; contents are only meaningful below r_depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_depth <= '0;
        end else if (i_clr) begin
            r_depth <= '0;
        end else if (w_do_push) begin
            r_depth <= r_depth + (AW+1)'(1);
        end else if (w_do_pop) begin
            r_depth <= r_depth - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_dir;
        end
    end

endmodule

`default_nettype wire

// File: rtl/junction_sequencer.sv
// ============================================================================
// junction_sequencer : left-hand depth-first maze solver driving the motor block
// Revision: 1.0
// ============================================================================
`default_nettype none

module junction_sequencer
    import car_pkg::*;
#(
    parameter int          STACK_DEPTH  = 16,
    parameter int          SETTLE_CYC   = 5_000_000,
    parameter int          MIN_TURN_CYC = 20_000_000,
    parameter int          TURN_TO_CYC  = 300_000_000,
    parameter int          LOST_CYC     = 10_000_000,
    parameter logic [19:0] OBST_DIST    = 20'd20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [2:0]                     detect,
    input  logic [19:0]                    distance,
    input  logic                           dist_valid,
    output logic [2:0]                     cmd,
    output logic [3:0]                     fsm_state,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           backtrack,
    output logic                           goal,
    output logic                           fault
);

    localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_MIN_LAST    = CNT_W'(MIN_TURN_CYC - 1);
    localparam logic [CNT_W-1:0] c_TO_LAST     = CNT_W'(TURN_TO_CYC - 1);
    localparam logic [CNT_W-1:0] c_LOST_LAST   = CNT_W'(LOST_CYC - 1);

    state_t                       r_state;
    state_t                       w_next;
    logic [CNT_W-1:0]             r_cnt;
    logic [CNT_W-1:0]             r_lost;
    logic                         r_popped;
    logic [1:0]                   r_pop_dir;
    logic                         r_backtrack;
    logic [2:0]                   r_cmd;
    logic [3:0]                   r_fsm;
    logic                         r_goal;
    logic                         r_fault;

    logic                         w_push;
    logic                         w_pop;
    logic [1:0]                   w_push_dir;
    logic                         w_set_popped;
    logic                         w_bt_clr;
    logic [1:0]                   w_top;
    logic [$clog2(STACK_DEPTH):0] w_depth;
    logic                         w_full;
    logic                         w_empty;

    turn_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (!enable),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dir   (w_push_dir),
        .o_top   (w_top),
        .o_depth (w_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next       = r_state;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_push_dir   = DIR_LEFT;
        w_set_popped = 1'b0;
        w_bt_clr     = 1'b0;
        if (!enable) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_next = ST_FOLLOW;
                ST_FOLLOW: begin
                    if (dist_valid && (distance < OBST_DIST)) begin
                        w_next = ST_UTURN;
                    end else if (detect == DET_ALL) begin
                        w_next = ST_SETTLE;
                    end else if ((detect == DET_NONE) && (r_lost == c_LOST_LAST)) begin
                        w_next = ST_UTURN;
                    end
                end
                ST_SETTLE: begin
                    // Second exit cycle after a pop: re-push the next branch, if any remains.
                    if (r_popped) begin
                        if (r_pop_dir != DIR_RIGHT) begin
                            w_push     = 1'b1;
                            w_push_dir = r_pop_dir + 2'd1;
                            w_bt_clr   = 1'b1;
                        end
                        w_next = ST_TURN;
                    end else if (r_cnt >= c_SETTLE_LAST) begin
                        if (detect == DET_ALL) begin
                            w_next = ST_GOAL;
                        end else if (!r_backtrack) begin
                            if (w_full) begin
                                w_next = ST_FAULT;
                            end else begin
                                w_push = 1'b1;
                                w_next = ST_TURN;
                            end
                        end else if (w_empty) begin
                            w_next = ST_EXHAUSTED;
                        end else begin
                            w_pop        = 1'b1;
                            w_set_popped = 1'b1;
                        end
                    end
                end
                ST_TURN, ST_UTURN: begin
                    if ((r_cnt >= c_MIN_LAST) && (detect == DET_M)) begin
                        w_next = ST_FOLLOW;
                    end else if (r_cnt >= c_TO_LAST) begin
                        w_next = ST_FAULT;
                    end
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_lost      <= '0;
            r_popped    <= 1'b0;
            r_pop_dir   <= 2'd0;
            r_backtrack <= 1'b0;
            r_cmd       <= CMD_STOP;
            r_fsm       <= ST_IDLE;
            r_goal      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_popped <= w_set_popped;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == ST_FOLLOW) && (w_next == ST_FOLLOW) && (detect == DET_NONE)) begin
                r_lost <= r_lost + CNT_W'(1);
            end else begin
                r_lost <= '0;
            end
            if (w_set_popped) begin
                r_pop_dir <= w_top;
            end
            if (!enable) begin
                r_backtrack <= 1'b0;
            end else if (r_state == ST_UTURN) begin
                r_backtrack <= 1'b1;
            end else if (w_bt_clr) begin
                r_backtrack <= 1'b0;
            end
            r_cmd   <= state_cmd(r_state);
            r_fsm   <= r_state;
            r_goal  <= enable && (r_state == ST_GOAL);
            r_fault <= enable && ((r_state == ST_FAULT) || (r_state == ST_EXHAUSTED));
        end
    end

    assign cmd       = r_cmd;
    assign fsm_state = r_fsm;
    assign depth     = w_depth;
    assign backtrack = r_backtrack;
    assign goal      = r_goal;
    assign fault     = r_fault;

endmodule

`default_nettype wire
